// File: rtl/trail_grid_pkg.sv
// trail_defs: shared constants and types for the light-cycle trail grid.
//   Grid geometry (COLS, ROWS, CELL_SHIFT, BORDER, GRID_DEPTH), 2-bit cell
//   codes, the pending-request record, the update FSM states and the
//   row-major cell address helper.
package trail_defs;

  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 60;
  localparam int unsigned CELL_SHIFT = 3;
  localparam int unsigned BORDER     = 2;
  localparam int unsigned GRID_DEPTH = COLS * ROWS;
  localparam int unsigned ADDR_W     = 13;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10,
    CELL_WALL  = 2'b11
  } cell_t;

  typedef struct packed {
    logic [6:0] col;
    logic [5:0] row;
  } req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_EV1,
    ST_RD2,
    ST_EV2
  } upd_state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col,
                                                  input logic [ADDR_W-1:0] cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/trail_grid_ram.sv
// trail_ram: simple dual-port DEPTH x 2 cell memory.
//   clk_i        clock
//   disp_addr_i  display read address, disp_rdata_o registered (1 cycle)
//   upd_addr_i   update port address, shared by read and write
//   upd_we_i     update write enable, upd_wdata_i write data
//   upd_rdata_o  registered update read data (read-first)
module trail_ram
  import trail_defs::*;
#(
  parameter int unsigned DEPTH = GRID_DEPTH
) (
  input  logic        clk_i,
  input  logic [12:0] disp_addr_i,
  output logic [1:0]  disp_rdata_o,
  input  logic [12:0] upd_addr_i,
  input  logic        upd_we_i,
  input  logic [1:0]  upd_wdata_i,
  output logic [1:0]  upd_rdata_o
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (upd_we_i) mem[upd_addr_i] <= upd_wdata_i;
    upd_rdata_o <= mem[upd_addr_i];
  end

  always_ff @(posedge clk_i) begin
    disp_rdata_o <= mem[disp_addr_i];
  end

endmodule

// File: rtl/trail_grid.sv
// trail_grid: cell-occupancy store for the light-cycle game.
//   VGA_CLK          sole clock; reset sync active-high (starts clear sweep)
//   reiniciar        round restart, starts clear sweep
//   next_x/next_y    pixel being fetched; saida_jogador1/2 = 8'd1 when the
//                    pixel's cell belongs to player 1/2 (2-cycle latency)
//   pN_valid/col/row head entered a new cell (pulse)
//   crash1/crash2    sticky collision flags; busy = clear sweep running
module trail_grid
  import trail_defs::*;
#(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 60,
  parameter int unsigned CELL_SHIFT = 3,
  parameter int unsigned BORDER     = 2
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       reiniciar,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic       p1_valid,
  input  logic [6:0] p1_col,
  input  logic [5:0] p1_row,
  input  logic       p2_valid,
  input  logic [6:0] p2_col,
  input  logic [5:0] p2_row,
  output logic [7:0] saida_jogador1,
  output logic [7:0] saida_jogador2,
  output logic       crash1,
  output logic       crash2,
  output logic       busy
);

  localparam int unsigned DEPTH = COLS * ROWS;
  localparam logic [12:0] COLS_W    = 13'(COLS);
  localparam logic [12:0] ROWS_W    = 13'(ROWS);
  localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);
  localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
  localparam logic [6:0]  COL_LO    = 7'(BORDER);
  localparam logic [6:0]  COL_HI    = 7'(COLS - BORDER);
  localparam logic [5:0]  ROW_LO    = 6'(BORDER);
  localparam logic [5:0]  ROW_HI    = 6'(ROWS - BORDER);
  localparam logic [9:0]  X_LIM     = 10'(COLS << CELL_SHIFT);
  localparam logic [9:0]  Y_LIM     = 10'(ROWS << CELL_SHIFT);

  function automatic logic req_oob(input req_t r);
    return ({6'b0, r.col} >= COLS_W) || ({7'b0, r.row} >= ROWS_W);
  endfunction

  // Out-of-range heads read address 0 so the RAM is never indexed past DEPTH.
  function automatic logic [12:0] req_addr(input req_t r);
    return req_oob(r) ? '0 : cell_addr({7'b0, r.row}, {6'b0, r.col}, COLS_W);
  endfunction

  upd_state_t  state_q, state_d;
  logic        busy_q, busy_d;
  logic [12:0] clr_addr_q, clr_addr_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [5:0]  clr_row_q, clr_row_d;
  logic        crash1_q, crash1_d, crash2_q, crash2_d;
  logic        pend1_q, pend1_d, pend2_q, pend2_d;
  req_t        slot1_q, slot1_d, slot2_q, slot2_d, work_q, work_d;

  logic [12:0] upd_addr;
  logic        upd_we;
  logic [1:0]  upd_wdata, upd_rdata;
  logic        clr_wall;
  logic        restart;

  logic [9:0]  disp_cx, disp_cy;
  logic        disp_in_range;
  logic [12:0] disp_addr;
  logic [1:0]  disp_rdata;
  logic        disp_ok_q;
  logic [7:0]  saida1_q, saida2_q;

  assign restart  = reset | reiniciar;
  assign clr_wall = (clr_col_q < COL_LO) || (clr_col_q >= COL_HI) ||
                    (clr_row_q < ROW_LO) || (clr_row_q >= ROW_HI);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    clr_addr_d = clr_addr_q;
    clr_col_d  = clr_col_q;
    clr_row_d  = clr_row_q;
    crash1_d   = crash1_q;
    crash2_d   = crash2_q;
    pend1_d    = pend1_q;
    pend2_d    = pend2_q;
    slot1_d    = slot1_q;
    slot2_d    = slot2_q;
    work_d     = work_q;
    upd_addr   = '0;
    upd_we     = 1'b0;
    upd_wdata  = CELL_EMPTY;

    if (busy_q) begin
      upd_addr  = clr_addr_q;
      upd_we    = 1'b1;
      upd_wdata = clr_wall ? CELL_WALL : CELL_EMPTY;
      if (clr_addr_q == LAST_ADDR) begin
        busy_d = 1'b0;
      end else begin
        clr_addr_d = clr_addr_q + 13'd1;
        if (clr_col_q == COL_LAST) begin
          clr_col_d = '0;
          clr_row_d = clr_row_q + 6'd1;
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end
    end else begin
      // The served request is copied into work_q at RD and the slot is released
      // there, so a pulse arriving during RD/EV is kept for the next pass.
      unique case (state_q)
        ST_IDLE: begin
          if (pend1_q)      state_d = ST_RD1;
          else if (pend2_q) state_d = ST_RD2;
        end
        ST_RD1: begin
          upd_addr = req_addr(slot1_q);
          work_d   = slot1_q;
          pend1_d  = 1'b0;
          state_d  = ST_EV1;
        end
        ST_EV1: begin
          upd_addr = req_addr(work_q);
          if (req_oob(work_q) || upd_rdata != CELL_EMPTY) begin
            crash1_d = 1'b1;
          end else begin
            upd_we    = 1'b1;
            upd_wdata = CELL_P1;
          end
          state_d = pend2_q ? ST_RD2 : ST_IDLE;
        end
        ST_RD2: begin
          upd_addr = req_addr(slot2_q);
          work_d   = slot2_q;
          pend2_d  = 1'b0;
          state_d  = ST_EV2;
        end
        ST_EV2: begin
          upd_addr = req_addr(work_q);
          if (req_oob(work_q) || upd_rdata != CELL_EMPTY) begin
            crash2_d = 1'b1;
          end else begin
            upd_we    = 1'b1;
            upd_wdata = CELL_P2;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (p1_valid) begin
        slot1_d = '{col: p1_col, row: p1_row};
        pend1_d = 1'b1;
      end
      if (p2_valid) begin
        slot2_d = '{col: p2_col, row: p2_row};
        pend2_d = 1'b1;
      end
    end

    if (restart) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b1;
      clr_addr_d = '0;
      clr_col_d  = '0;
      clr_row_d  = '0;
      crash1_d   = 1'b0;
      crash2_d   = 1'b0;
      pend1_d    = 1'b0;
      pend2_d    = 1'b0;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b1;
      clr_addr_q <= '0;
      clr_col_q  <= '0;
      clr_row_q  <= '0;
      crash1_q   <= 1'b0;
      crash2_q   <= 1'b0;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      slot1_q    <= '0;
      slot2_q    <= '0;
      work_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      clr_addr_q <= clr_addr_d;
      clr_col_q  <= clr_col_d;
      clr_row_q  <= clr_row_d;
      crash1_q   <= crash1_d;
      crash2_q   <= crash2_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      slot1_q    <= slot1_d;
      slot2_q    <= slot2_d;
      work_q     <= work_d;
    end
  end

  assign disp_cx       = next_x >> CELL_SHIFT;
  assign disp_cy       = next_y >> CELL_SHIFT;
  assign disp_in_range = (next_x < X_LIM) && (next_y < Y_LIM);
  assign disp_addr     = disp_in_range ? cell_addr({3'b0, disp_cy}, {3'b0, disp_cx}, COLS_W) : '0;

  // Qualifier travels alongside the RAM read so both outputs line up at stage 2.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      disp_ok_q <= 1'b0;
      saida1_q  <= '0;
      saida2_q  <= '0;
    end else begin
      disp_ok_q <= disp_in_range && !busy_q;
      saida1_q  <= {7'b0, disp_ok_q && (disp_rdata == CELL_P1)};
      saida2_q  <= {7'b0, disp_ok_q && (disp_rdata == CELL_P2)};
    end
  end

  trail_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i       (VGA_CLK),
    .disp_addr_i (disp_addr),
    .disp_rdata_o(disp_rdata),
    .upd_addr_i  (upd_addr),
    .upd_we_i    (upd_we),
    .upd_wdata_i (upd_wdata),
    .upd_rdata_o (upd_rdata)
  );

  assign saida_jogador1 = saida1_q;
  assign saida_jogador2 = saida2_q;
  assign crash1         = crash1_q;
  assign crash2         = crash2_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_trail_grid.sv
// Testbench for trail_grid: directed display-vector table plus hand-written
// sequences for sweep timing, update latency, collisions and restart.
`timescale 1ns/1ps
module tb_trail_grid;

  logic       VGA_CLK = 1'b0;
  logic       reset = 1'b1, reiniciar = 1'b0;
  logic [9:0] next_x = '0, next_y = '0;
  logic       p1_valid = 1'b0, p2_valid = 1'b0;
  logic [6:0] p1_col = '0, p2_col = '0;
  logic [5:0] p1_row = '0, p2_row = '0;
  logic [7:0] saida_jogador1, saida_jogador2;
  logic       crash1, crash2, busy;

  int n_cmp = 0;
  int n_bad = 0;

  trail_grid dut (
    .VGA_CLK       (VGA_CLK),
    .reset         (reset),
    .reiniciar     (reiniciar),
    .next_x        (next_x),
    .next_y        (next_y),
    .p1_valid      (p1_valid),
    .p1_col        (p1_col),
    .p1_row        (p1_row),
    .p2_valid      (p2_valid),
    .p2_col        (p2_col),
    .p2_row        (p2_row),
    .saida_jogador1(saida_jogador1),
    .saida_jogador2(saida_jogador2),
    .crash1        (crash1),
    .crash2        (crash2),
    .busy          (busy)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, required finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int x;
    int y;
    int e1;
    int e2;
  } dvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  function automatic logic [1:0] peek(input int col, input int row);
    return dut.u_ram.mem[row * 80 + col];
  endfunction

  task automatic disp(input string name, input int x, input int y, input int e1, input int e2);
    next_x = 10'(x);
    next_y = 10'(y);
    tick();
    tick();
    check({name, "_p1"}, {24'b0, saida_jogador1}, e1);
    check({name, "_p2"}, {24'b0, saida_jogador2}, e2);
  endtask

  task automatic pulse(input int who, input int col, input int row);
    if (who == 1) begin p1_valid = 1'b1; p1_col = 7'(col); p1_row = 6'(row); end
    else          begin p2_valid = 1'b1; p2_col = 7'(col); p2_row = 6'(row); end
    tick();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 6000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    dvec_t tbl[11];
    int n;
    int bad_cells;
    tbl[0]  = '{0,    0,    0, 0};
    tbl[1]  = '{320,  240,  1, 0};
    tbl[2]  = '{327,  247,  1, 0};
    tbl[3]  = '{328,  240,  0, 0};
    tbl[4]  = '{319,  247,  0, 0};
    tbl[5]  = '{320,  248,  0, 0};
    tbl[6]  = '{160,  160,  0, 1};
    tbl[7]  = '{167,  167,  0, 1};
    tbl[8]  = '{640,  240,  0, 0};
    tbl[9]  = '{320,  480,  0, 0};
    tbl[10] = '{1023, 1023, 0, 0};

    // Reset and initial sweep
    reset = 1'b1;
    tick();
    check("rst_busy", busy, 1);
    check("rst_saida1", saida_jogador1, 0);
    check("rst_saida2", saida_jogador2, 0);
    check("rst_crash1", crash1, 0);
    check("rst_crash2", crash2, 0);
    reset = 1'b0;
    wait_sweep(n);
    check("sweep_len", n, 4800);
    check("cell_0_0_wall", peek(0, 0), 3);
    check("cell_79_59_wall", peek(79, 59), 3);
    check("cell_1_5_wall", peek(1, 5), 3);
    check("cell_2_2_empty", peek(2, 2), 0);
    check("cell_40_30_empty", peek(40, 30), 0);
    disp("scan_0_0", 0, 0, 0, 0);
    disp("scan_320_240", 320, 240, 0, 0);

    // Player 1 write latency
    pulse(1, 40, 30);
    tick();
    tick();
    check("p1_write_early", peek(40, 30), 0);
    tick();
    check("p1_write", peek(40, 30), 1);
    check("p1_no_crash", crash1, 0);

    // Player 2 into occupied cell
    pulse(2, 40, 30);
    tick();
    tick();
    tick();
    check("p2_crash", crash2, 1);
    check("p2_crash_p1flag", crash1, 0);
    check("p2_cell_kept", peek(40, 30), 1);

    // Player 1 out of range; player 2 (already crashed) still writes
    pulse(1, 80, 5);
    repeat (3) tick();
    check("oob_crash1", crash1, 1);
    check("oob_no_write", peek(0, 6), 3);
    pulse(2, 20, 20);
    repeat (3) tick();
    check("p2_write", peek(20, 20), 2);

    for (int i = 0; i < 11; i++) begin
      disp($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].e1, tbl[i].e2);
    end

    // Restart mid-sweep at address 2000
    reiniciar = 1'b1;
    tick();
    reiniciar = 1'b0;
    check("rest_busy", busy, 1);
    check("rest_crash1", crash1, 0);
    check("rest_crash2", crash2, 0);
    repeat (1997) tick();
    disp("busy_gate", 320, 240, 0, 0);
    tick();
    check("mid_sweep_cleared", peek(79, 24), 3);
    check("mid_sweep_pending", peek(40, 30), 1);
    reiniciar = 1'b1;
    tick();
    reiniciar = 1'b0;
    pulse(1, 30, 30);
    wait_sweep(n);
    check("restart_len", n + 1, 4800);
    repeat (6) tick();
    check("ignored_req", peek(30, 30), 0);
    check("post_crash1", crash1, 0);
    check("post_crash2", crash2, 0);
    bad_cells = 0;
    for (int r = 0; r < 60; r++) begin
      for (int c = 0; c < 80; c++) begin
        if (peek(c, r) != ((c < 2 || c >= 78 || r < 2 || r >= 58) ? 2'd3 : 2'd0))
          bad_cells++;
      end
    end
    check("sweep_contents", bad_cells, 0);

    // Head-on entry into the same cell
    p1_valid = 1'b1; p1_col = 7'd10; p1_row = 6'd10;
    p2_valid = 1'b1; p2_col = 7'd10; p2_row = 6'd10;
    tick();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    repeat (4) tick();
    check("headon_crash2_early", crash2, 0);
    tick();
    check("headon_crash2", crash2, 1);
    check("headon_crash1", crash1, 0);
    check("headon_cell", peek(10, 10), 1);
    disp("headon_scan", 80, 80, 1, 0);

    // Wall hit
    pulse(1, 1, 5);
    repeat (3) tick();
    check("wall_crash1", crash1, 1);
    check("wall_cell", peek(1, 5), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
